// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 register file holding SR, Cause, EPC and PRId.
// Raises a single exception/interrupt request in M stage, records the
// victim state on the request edge, and supplies the eret return address.
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h4B46_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out
);

  localparam logic [4:0] A_SR    = 5'd12;
  localparam logic [4:0] A_CAUSE = 5'd13;
  localparam logic [4:0] A_EPC   = 5'd14;
  localparam logic [4:0] A_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        int_req, exc_req;
  logic [31:0] vpc_al, epc_tgt;

  // Request decode; interrupts use live hw_int lines, and EXL blocks nesting.
  always_comb begin
    int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
    exc_req = (exc_code_in != 5'd0) & ~exl_q;
    req     = int_req | exc_req;
    vpc_al  = vpc & 32'hFFFF_FFFC;
    epc_tgt = bd_in ? (vpc_al - 32'd4) : vpc_al;
  end

  // Next-state: request beats mtc0; eret clears EXL only when no request.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hw_int;
    exc_d = exc_q;
    epc_d = epc_q;
    if (req) begin
      exl_d = 1'b1;
      bd_d  = bd_in;
      exc_d = int_req ? 5'd0 : exc_code_in;
      epc_d = epc_tgt;
    end else begin
      if (en) begin
        case (addr)
          A_SR: begin
            im_d  = din[15:10];
            exl_d = din[1];
            ie_d  = din[0];
          end
          A_EPC:   epc_d = din;
          default: ;
        endcase
      end
      if (eret) exl_d = 1'b0;
    end
  end

  // State register with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  // mfc0 read mux and eret target with same-cycle mtc0 EPC forwarding.
  always_comb begin
    case (addr)
      A_SR:    dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
      A_CAUSE: dout = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
      A_EPC:   dout = epc_q;
      A_PRID:  dout = PRID;
      default: dout = 32'd0;
    endcase
    epc_out = (en && addr == A_EPC) ? din : epc_q;
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed + random stimulus; per-cycle expected outputs are
// queued by the driver and checked by an independent negedge monitor.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset, en, bd_in, eret, req;
  logic [4:0]  addr, exc_code_in;
  logic [31:0] din, dout, vpc, epc_out;
  logic [5:0]  hw_int;

  cp0_unit dut (
    .clk(clk), .reset(reset), .en(en), .addr(addr), .din(din), .dout(dout),
    .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
    .eret(eret), .req(req), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        req;
    logic [31:0] dout;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_on = 1'b0;

  // Reference model: architectural registers as whole words.
  logic [31:0] m_sr, m_cause, m_epc;

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (req !== e.req) begin
        n_fail++;
        $display("FAIL %s req: got %b expected %b", e.tag, req, e.req);
      end
      n_chk++;
      if (dout !== e.dout) begin
        n_fail++;
        $display("FAIL %s dout: got %h expected %h", e.tag, dout, e.dout);
      end
      n_chk++;
      if (epc_out !== e.epc) begin
        n_fail++;
        $display("FAIL %s epc_out: got %h expected %h", e.tag, epc_out, e.epc);
      end
    end
  end

  task automatic cyc(input string tag, input logic r, input logic e,
                     input logic [4:0] a, input logic [31:0] d,
                     input logic [31:0] v, input logic b,
                     input logic [4:0] c, input logic [5:0] h, input logic er);
    exp_t x;
    bit exl, ie, intr, exc, rq;
    logic [31:0] rd;
    @(posedge clk); #1;
    reset = r; en = e; addr = a; din = d; vpc = v; bd_in = b;
    exc_code_in = c; hw_int = h; eret = er;
    exl  = m_sr[1];
    ie   = m_sr[0];
    intr = ((h & m_sr[15:10]) != 6'd0) && ie && !exl;
    exc  = (c != 5'd0) && !exl;
    rq   = intr || exc;
    case (a)
      5'd12:   rd = m_sr;
      5'd13:   rd = m_cause;
      5'd14:   rd = m_epc;
      5'd15:   rd = 32'h4B46_0001;
      default: rd = 32'd0;
    endcase
    x.tag = tag; x.req = rq; x.dout = rd;
    x.epc = (e && a == 5'd14) ? d : m_epc;
    if (chk_on) exp_q.push_back(x);
    // state after the coming edge
    if (r) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(h) << 10);
      if (rq) begin
        m_sr    = m_sr | 32'd2;
        m_cause = (m_cause & 32'h0000_FC00) | (32'(b) << 31)
                  | (32'(intr ? 5'd0 : c) << 2);
        m_epc   = (v / 4) * 4 - (b ? 32'd4 : 32'd0);
      end else begin
        if (e && a == 5'd12) m_sr  = d & 32'h0000_FC03;
        if (e && a == 5'd14) m_epc = d;
        if (er) m_sr = m_sr & ~32'd2;
      end
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [5:0] h);
    cyc(tag, 1'b0, 1'b0, a, 32'd0, 32'd0, 1'b0, 5'd0, h, 1'b0);
  endtask

  initial begin
    reset = 1'b1; en = 0; addr = 0; din = 0; vpc = 0; bd_in = 0;
    exc_code_in = 0; hw_int = 0; eret = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    // first reset cycle: DUT state is still unknown
    cyc("rst0", 1, 0, 5'd12, 0, 0, 0, 0, 0, 0);
    chk_on = 1'b1;
    cyc("rst1", 1, 1, 5'd14, 32'h1234, 32'h80, 0, 5'd3, 6'h3F, 1);
    rd("post_rst_sr", 5'd12, 0);
    rd("post_rst_cause", 5'd13, 0);
    // interrupt path
    cyc("mtc0_sr", 0, 1, 5'd12, 32'h0000_0401, 0, 0, 0, 0, 0);
    cyc("hw_int", 0, 0, 5'd12, 0, 32'h0000_1000, 0, 0, 6'b000001, 0);
    rd("int_sr", 5'd12, 6'b000001);
    rd("int_cause", 5'd13, 6'b000001);
    rd("int_epc", 5'd14, 0);
    // exception in delay slot
    cyc("eret1", 0, 0, 5'd12, 0, 0, 0, 0, 0, 1);
    cyc("exc4", 0, 0, 5'd13, 0, 32'h0000_3010, 1, 5'd4, 0, 0);
    rd("exc4_cause", 5'd13, 0);
    rd("exc4_epc", 5'd14, 0);
    // no nesting while EXL=1
    cyc("nest", 0, 0, 5'd13, 0, 32'h0000_5000, 0, 5'd10, 6'b000001, 0);
    rd("nest_cause", 5'd13, 6'b000010);
    rd("nest_epc", 5'd14, 0);
    cyc("eret2", 0, 0, 5'd12, 0, 0, 0, 0, 0, 1);
    rd("eret2_sr", 5'd12, 0);
    // mtc0 EPC forwarded during eret
    cyc("fwd", 0, 1, 5'd14, 32'h0000_3400, 0, 0, 0, 0, 1);
    rd("fwd_epc", 5'd14, 0);
    // interrupt beats exception; en ignored
    cyc("sr_im12", 0, 1, 5'd12, 32'h0000_1001, 0, 0, 0, 0, 0);
    cyc("int_exc", 0, 1, 5'd14, 32'hDEAD_BEEF, 32'h0000_2008, 0, 5'd12, 6'b000100, 0);
    rd("int_exc_cause", 5'd13, 0);
    rd("int_exc_epc", 5'd14, 0);
    // PRId and unmapped
    rd("prid", 5'd15, 0);
    rd("unmapped", 5'd7, 0);
    // reset mid-handler clears EXL
    cyc("rst_mid", 1, 0, 5'd12, 0, 0, 0, 0, 0, 0);
    rd("rst_mid_sr", 5'd12, 0);
    cyc("after_rst_exc", 0, 0, 5'd14, 0, 32'h0000_4444, 0, 5'd8, 0, 0);
    rd("after_rst_epc", 5'd14, 0);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic r, e, b, er;
      logic [4:0] a, c;
      logic [31:0] d, v;
      logic [5:0] h;
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: a = 5'd12; 1: a = 5'd13; 2: a = 5'd14; 3: a = 5'd15;
        default: a = 5'($urandom);
      endcase
      d  = $urandom;
      v  = $urandom;
      b  = 1'($urandom);
      c  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      h  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      er = ($urandom_range(0, 5) == 0);
      if (e && a == 5'd12) er = 1'b0;
      cyc("rand", r, e, a, d, v, b, c, h, er);
    end
    rd("final", 5'd12, 0);
    // drain with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
